// File: rtl/mod_seq_pkg.sv
// Shared types and defaults for the modulation-mode sequencer.
// Mode encodings match the modulator / Nios mode PIO register values.
package mod_seq_pkg;

    localparam int DEFAULT_NUM_MODES = 4;
    localparam int DEFAULT_DWELL_S   = 2;
    localparam int DWELL_CNT_W       = 8;

    typedef enum logic [1:0] {
        MOD_ASK  = 2'd0,
        MOD_FSK  = 2'd1,
        MOD_PSK  = 2'd2,
        MOD_QPSK = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        DWELL   = 2'd2
    } seq_state_e;

    // Modulo-increment of a mode index; the last mode wraps back to the first.
    function automatic int next_mode_idx(input int cur, input int num_modes);
        return (cur >= num_modes - 1) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/mod_mode_sequencer_rise_edge_det.sv
// Rising-edge detector for a slow level generated in the clk_50 domain.
// Emits a one-cycle registered pulse the cycle after the level is first seen high.
module rise_edge_det (
    input  logic clk_50,
    input  logic reset_n,
    input  logic d,
    output logic pulse
);

    logic d_q;

    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            d_q   <= 1'b0;
            pulse <= 1'b0;
        end else begin
            d_q   <= d;
            pulse <= d & ~d_q;
        end
    end

endmodule

// File: rtl/mod_mode_sequencer.sv
// Steps the modulation mode on a fixed number of 1 Hz ticks and offers each
// new mode to the modulator over a valid/ready handshake.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | sequencing disabled, nothing offered, mode_sel retained
//   PRESENT | mode_sel offered (mode_valid=1), waiting for mode_ready
//   DWELL   | mode accepted, counting ticks until the next mode is due
module mod_mode_sequencer
    import mod_seq_pkg::*;
#(
    parameter  int NUM_MODES = DEFAULT_NUM_MODES,
    parameter  int DWELL_S   = DEFAULT_DWELL_S,
    localparam int MODE_W    = $clog2(NUM_MODES)
) (
    input  logic              clk_50,
    input  logic              reset_n,
    input  logic              clk_1hz,
    input  logic              enable,
    input  logic              hold,
    input  logic              mode_ready,
    input  logic              overrun_clr,
    output logic [MODE_W-1:0] mode_sel,
    output logic              mode_valid,
    output logic              tick_1hz,
    output logic [7:0]        dwell_cnt,
    output logic              overrun
);

    localparam logic [DWELL_CNT_W-1:0] DWELL_LAST = DWELL_CNT_W'(DWELL_S - 1);

    seq_state_e              state_q, state_d;
    logic [MODE_W-1:0]       mode_q, mode_d, mode_inc;
    logic [DWELL_CNT_W-1:0]  dwell_q, dwell_d;
    logic                    overrun_q, overrun_d;
    logic                    overrun_set;

    rise_edge_det u_tick_det (
        .clk_50  (clk_50),
        .reset_n (reset_n),
        .d       (clk_1hz),
        .pulse   (tick_1hz)
    );

    assign mode_inc = MODE_W'(next_mode_idx(32'(mode_q), NUM_MODES));

    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            mode_q    <= '0;
            dwell_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            dwell_q   <= dwell_d;
            overrun_q <= overrun_d;
        end
    end

    // Dropping enable wins over anything else that cycle, including a tick
    // that would otherwise flag an overrun or a ready completing a handshake.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        dwell_d     = dwell_q;
        overrun_set = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            dwell_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = PRESENT;
                end
                PRESENT: begin
                    overrun_set = tick_1hz;
                    if (mode_ready) begin
                        state_d = DWELL;
                        dwell_d = '0;
                    end
                end
                DWELL: begin
                    if (tick_1hz && !hold) begin
                        if (dwell_q == DWELL_LAST) begin
                            state_d = PRESENT;
                            mode_d  = mode_inc;
                            dwell_d = '0;
                        end else begin
                            dwell_d = dwell_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    dwell_d = '0;
                end
            endcase
        end

        overrun_d = overrun_set | (overrun_q & ~overrun_clr);
    end

    assign mode_sel   = mode_q;
    assign mode_valid = (state_q == PRESENT);
    assign dwell_cnt  = dwell_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_mod_mode_sequencer.sv
// Self-checking bench for mod_mode_sequencer with a shortened 1 Hz input.
// Accepted modes are checked against a queue of expected modes.
module tb_mod_mode_sequencer;

    logic       clk_50 = 1'b0;
    logic       reset_n = 1'b0;
    logic       clk_1hz = 1'b0;
    logic       enable = 1'b0;
    logic       hold = 1'b0;
    logic       mode_ready = 1'b0;
    logic       overrun_clr = 1'b0;
    logic [1:0] mode_sel;
    logic       mode_valid;
    logic       tick_1hz;
    logic [7:0] dwell_cnt;
    logic       overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];

    mod_mode_sequencer #(.NUM_MODES(4), .DWELL_S(2)) dut (
        .clk_50      (clk_50),
        .reset_n     (reset_n),
        .clk_1hz     (clk_1hz),
        .enable      (enable),
        .hold        (hold),
        .mode_ready  (mode_ready),
        .overrun_clr (overrun_clr),
        .mode_sel    (mode_sel),
        .mode_valid  (mode_valid),
        .tick_1hz    (tick_1hz),
        .dwell_cnt   (dwell_cnt),
        .overrun     (overrun)
    );

    always #5 clk_50 = ~clk_50;

    // Shortened "1 Hz": 20-cycle half-period, changing just after a clk_50 edge.
    initial begin
        forever begin
            repeat (20) @(posedge clk_50);
            #1 clk_1hz = ~clk_1hz;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Every accepted handshake must carry the next expected mode.
    always @(negedge clk_50) begin
        if (reset_n && mode_valid && mode_ready) begin
            if (exp_q.size() == 0)
                chk("hs_unexpected", 32'(mode_sel), -1);
            else
                chk("hs_mode", 32'(mode_sel), exp_q.pop_front());
        end
    end

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk_50);
            n++;
        end while (tick_1hz !== 1'b1 && n < 100);
        if (tick_1hz !== 1'b1) chk("tick_timeout", 0, 1);
    endtask

    task automatic drive_slot();
        @(posedge clk_50);
        #1;
    endtask

    task automatic settle();
        @(posedge clk_50);
        @(negedge clk_50);
    endtask

    initial begin
        int rst_bad;

        // 1: reset held across a clk_1hz rising edge
        rst_bad = 0;
        repeat (45) begin
            @(negedge clk_50);
            if (tick_1hz !== 1'b0 || mode_valid !== 1'b0 || overrun !== 1'b0
                || dwell_cnt !== 8'd0 || mode_sel !== 2'd0)
                rst_bad++;
        end
        chk("rst_outputs_quiet", rst_bad, 0);
        do @(negedge clk_50); while (clk_1hz !== 1'b0);
        reset_n = 1'b1;
        @(negedge clk_50);
        chk("rel_tick", 32'(tick_1hz), 0);
        chk("rel_valid", 32'(mode_valid), 0);
        chk("rel_mode", 32'(mode_sel), 0);
        chk("rel_dwell", 32'(dwell_cnt), 0);
        chk("rel_overrun", 32'(overrun), 0);

        // 2: free-running sequence with ready held high
        drive_slot();
        exp_q.push_back(0);
        enable = 1'b1;
        mode_ready = 1'b1;
        settle();
        chk("t2_valid_first", 32'(mode_valid), 1);
        @(negedge clk_50);
        chk("t2_valid_one_cycle", 32'(mode_valid), 0);
        chk("t2_dwell0", 32'(dwell_cnt), 0);
        for (int m = 1; m <= 4; m++) begin
            wait_tick();
            @(negedge clk_50);
            chk("t2_dwell1", 32'(dwell_cnt), 1);
            chk("t2_mode_held", 32'(mode_sel), (m + 3) % 4);
            exp_q.push_back(m % 4);
            wait_tick();
            @(negedge clk_50);
            chk("t2_advance_valid", 32'(mode_valid), 1);
            chk("t2_advance_mode", 32'(mode_sel), m % 4);
            chk("t2_advance_dwell", 32'(dwell_cnt), 0);
        end

        // 3: ready low, ticks while a mode is pending
        drive_slot();
        mode_ready = 1'b0;
        exp_q.push_back(1);
        wait_tick();
        @(negedge clk_50);
        wait_tick();
        @(negedge clk_50);
        chk("t3_pending_mode", 32'(mode_sel), 1);
        chk("t3_pending_valid", 32'(mode_valid), 1);
        chk("t3_no_overrun_yet", 32'(overrun), 0);
        wait_tick();
        @(negedge clk_50);
        chk("t3_overrun_set", 32'(overrun), 1);
        chk("t3_tick_not_counted", 32'(dwell_cnt), 0);
        wait_tick();
        @(negedge clk_50);
        chk("t3_still_valid", 32'(mode_valid), 1);
        chk("t3_still_mode1", 32'(mode_sel), 1);
        drive_slot();
        mode_ready = 1'b1;
        @(negedge clk_50);
        @(negedge clk_50);
        chk("t3_accept_valid", 32'(mode_valid), 0);
        chk("t3_accept_dwell", 32'(dwell_cnt), 0);
        chk("t3_overrun_sticky", 32'(overrun), 1);

        // 4: hold freezes the dwell count
        wait_tick();
        @(negedge clk_50);
        chk("t4_dwell1", 32'(dwell_cnt), 1);
        drive_slot();
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_tick();
            @(negedge clk_50);
            chk("t4_hold_dwell", 32'(dwell_cnt), 1);
            chk("t4_hold_mode", 32'(mode_sel), 1);
            chk("t4_hold_valid", 32'(mode_valid), 0);
        end
        drive_slot();
        hold = 1'b0;
        mode_ready = 1'b0;
        wait_tick();
        @(negedge clk_50);
        chk("t4_release_mode", 32'(mode_sel), 2);
        chk("t4_release_valid", 32'(mode_valid), 1);

        // 5: disable during a pending handshake, then re-present
        drive_slot();
        enable = 1'b0;
        settle();
        chk("t5_idle_valid", 32'(mode_valid), 0);
        chk("t5_idle_mode", 32'(mode_sel), 2);
        chk("t5_idle_dwell", 32'(dwell_cnt), 0);
        @(negedge clk_50);
        chk("t5_stays_idle", 32'(mode_valid), 0);
        drive_slot();
        exp_q.push_back(2);
        enable = 1'b1;
        mode_ready = 1'b1;
        settle();
        chk("t5_represent_valid", 32'(mode_valid), 1);
        chk("t5_represent_mode", 32'(mode_sel), 2);
        @(negedge clk_50);
        chk("t5_accepted", 32'(mode_valid), 0);

        // 6: clear vs. simultaneous set
        overrun_clr = 1'b1;
        @(negedge clk_50);
        overrun_clr = 1'b0;
        chk("t6_clr", 32'(overrun), 0);
        drive_slot();
        mode_ready = 1'b0;
        wait_tick();
        @(negedge clk_50);
        wait_tick();
        @(negedge clk_50);
        chk("t6_pending_mode", 32'(mode_sel), 3);
        chk("t6_pending_no_overrun", 32'(overrun), 0);
        wait_tick();
        overrun_clr = 1'b1;
        @(negedge clk_50);
        overrun_clr = 1'b0;
        chk("t6_set_wins", 32'(overrun), 1);
        repeat (3) @(negedge clk_50);
        chk("t6_sticky", 32'(overrun), 1);
        overrun_clr = 1'b1;
        @(negedge clk_50);
        overrun_clr = 1'b0;
        chk("t6_clr_alone", 32'(overrun), 0);
        drive_slot();
        exp_q.push_back(3);
        mode_ready = 1'b1;
        @(negedge clk_50);
        @(negedge clk_50);
        chk("t6_final_accept", 32'(mode_valid), 0);

        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
